// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait timeout and a sticky TRAP.
// Strobes are decoded from the current state and mem_ready; a run flag holds them low until the first edge after reset.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_SD  = 3'd3,
    C_BEQ = 3'd4
  } cls_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur, nxt;
  cls_t       cls, dec_cls;
  logic       dec_ok;
  logic       run;
  logic [7:0] wait_cnt;
  logic       timed_out;
  logic       retire;

  always_comb begin
    dec_ok  = 1'b1;
    dec_cls = C_R;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LD;
      7'b0100011: dec_cls = C_SD;
      7'b1100011: dec_cls = C_BEQ;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // The last waiting cycle traps unless mem_ready arrives in that same cycle.
  assign timed_out = !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH: begin
        if (run) begin
          if (mem_ready)      nxt = S_DECODE;
          else if (timed_out) nxt = S_TRAP;
        end
      end
      S_DECODE: nxt = dec_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (cls)
          C_LD, C_SD: nxt = S_MEM;
          C_BEQ:      nxt = S_FETCH;
          default:    nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready)      nxt = (cls == C_SD) ? S_FETCH : S_WB;
        else if (timed_out) nxt = S_TRAP;
      end
      S_WB:    nxt = S_FETCH;
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    case (cur)
      S_FETCH: begin
        if (run) begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
      end
      S_EXEC: begin
        case (cls)
          C_R:     alu_op = 2'b10;
          C_I:     begin alu_op = 2'b11; alu_src = 1'b1; end
          C_BEQ:   begin alu_op = 2'b01; pc_src = 1'b1; pc_write = zero; end
          default: alu_src = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == C_SD);
        alu_src = 1'b1;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls == C_LD);
      end
      default: ;
    endcase
  end

  assign state   = cur;
  assign illegal = (cur == S_TRAP);
  assign retire  = (cur == S_WB)
                 || (cur == S_MEM  && mem_ready && cls == C_SD)
                 || (cur == S_EXEC && cls == C_BEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      wait_cnt <= 8'd0;
      cls      <= C_R;
      retired  <= 32'd0;
    end else begin
      run <= 1'b1;
      if (nxt != cur)
        wait_cnt <= 8'd0;
      else if (run && !mem_ready && (cur == S_FETCH || cur == S_MEM))
        wait_cnt <= wait_cnt + 8'd1;
      if (cur == S_DECODE && dec_ok)
        cls <= dec_cls;
      if (retire)
        retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus hand sequences for trap, timeout and async reset.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, alu_src, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .alu_op(alu_op), .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // {mem_req mem_we}_{ir_write pc_write pc_src}_{reg_write mem_to_reg}_{alu_src alu_op}_{illegal}
  logic [10:0] outs;
  logic [4:0]  strobes;
  assign outs    = {mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
                    alu_src, alu_op, illegal};
  assign strobes = {mem_req, mem_we, ir_write, pc_write, reg_write};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [2:0]  st;
    logic [10:0] o;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input logic r, input logic [6:0] op, input logic z, input logic mr,
                     input logic [2:0] st, input logic [10:0] o, input logic [31:0] ret);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.o = o; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic cycle(input logic r, input logic [6:0] op, input logic z, input logic mr);
    @(negedge clk);
    rst_n = r; opcode = op; zero = z; mem_ready = mr;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;

    // reset and release: nothing asserted until the first edge after release
    add(0, OP_R, 0, 1, 3'd0, 11'b00_000_00_000_0, 0);
    add(0, OP_R, 0, 1, 3'd0, 11'b00_000_00_000_0, 0);
    add(1, OP_R, 0, 0, 3'd0, 11'b00_000_00_000_0, 0);
    // R-type, zero wait
    add(1, OP_R, 0, 1, 3'd0, 11'b10_110_00_000_0, 0);
    add(1, OP_R, 0, 0, 3'd1, 11'b00_000_00_000_0, 0);
    add(1, OP_R, 1, 1, 3'd2, 11'b00_000_00_010_0, 0);
    add(1, OP_R, 0, 0, 3'd4, 11'b00_000_10_000_0, 0);
    // LD, three wait cycles in MEM
    add(1, OP_LD, 0, 1, 3'd0, 11'b10_110_00_000_0, 1);
    add(1, OP_LD, 0, 0, 3'd1, 11'b00_000_00_000_0, 1);
    add(1, OP_LD, 0, 0, 3'd2, 11'b00_000_00_100_0, 1);
    add(1, OP_LD, 0, 0, 3'd3, 11'b10_000_00_100_0, 1);
    add(1, OP_LD, 0, 0, 3'd3, 11'b10_000_00_100_0, 1);
    add(1, OP_LD, 0, 0, 3'd3, 11'b10_000_00_100_0, 1);
    add(1, OP_LD, 0, 1, 3'd3, 11'b10_000_00_100_0, 1);
    add(1, OP_LD, 0, 0, 3'd4, 11'b00_000_11_000_0, 1);
    // SD, zero wait
    add(1, OP_SD, 0, 1, 3'd0, 11'b10_110_00_000_0, 2);
    add(1, OP_SD, 0, 0, 3'd1, 11'b00_000_00_000_0, 2);
    add(1, OP_SD, 0, 0, 3'd2, 11'b00_000_00_100_0, 2);
    add(1, OP_SD, 0, 1, 3'd3, 11'b11_000_00_100_0, 2);
    // BEQ taken, then not taken
    add(1, OP_BEQ, 0, 1, 3'd0, 11'b10_110_00_000_0, 3);
    add(1, OP_BEQ, 0, 0, 3'd1, 11'b00_000_00_000_0, 3);
    add(1, OP_BEQ, 1, 0, 3'd2, 11'b00_011_00_001_0, 3);
    add(1, OP_BEQ, 1, 1, 3'd0, 11'b10_110_00_000_0, 4);
    add(1, OP_BEQ, 1, 0, 3'd1, 11'b00_000_00_000_0, 4);
    add(1, OP_BEQ, 0, 0, 3'd2, 11'b00_001_00_001_0, 4);
    // I-type with one FETCH wait cycle
    add(1, OP_I, 0, 0, 3'd0, 11'b10_000_00_000_0, 5);
    add(1, OP_I, 0, 1, 3'd0, 11'b10_110_00_000_0, 5);
    add(1, OP_I, 0, 0, 3'd1, 11'b00_000_00_000_0, 5);
    add(1, OP_I, 0, 0, 3'd2, 11'b00_000_00_111_0, 5);
    add(1, OP_I, 0, 0, 3'd4, 11'b00_000_10_000_0, 5);
    add(1, OP_I, 0, 0, 3'd0, 11'b10_000_00_000_0, 6);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr);
      check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d outs", i), 32'(outs), 32'(vecs[i].o));
      check($sformatf("vec%0d retired", i), retired, vecs[i].ret);
    end

    // illegal opcode traps after DECODE and stays there
    cycle(1, OP_BAD, 0, 1);
    check("bad fetch ir_write", 32'(ir_write), 1);
    cycle(1, OP_BAD, 0, 0);
    check("bad decode state", 32'(state), 1);
    for (int k = 0; k < 20; k++) begin
      cycle(1, OP_R, 1, k[0]);
      check($sformatf("trap%0d state", k), 32'(state), 5);
      check($sformatf("trap%0d illegal", k), 32'(illegal), 1);
      check($sformatf("trap%0d strobes", k), 32'(strobes), 0);
    end
    check("trap retired", retired, 6);
    cycle(0, OP_R, 0, 0);
    check("rst illegal", 32'(illegal), 0);
    check("rst state", 32'(state), 0);
    check("rst retired", retired, 0);
    cycle(1, OP_R, 0, 0);
    check("release mem_req", 32'(mem_req), 0);

    // FETCH timeout after four wait cycles
    for (int k = 0; k < 4; k++) begin
      cycle(1, OP_R, 0, 0);
      check($sformatf("to%0d state", k), 32'(state), 0);
      check($sformatf("to%0d mem_req", k), 32'(mem_req), 1);
    end
    cycle(1, OP_R, 0, 1);
    check("timeout state", 32'(state), 5);
    check("timeout illegal", 32'(illegal), 1);

    // mem_ready on the limit cycle wins; then SD aborted by reset in MEM
    cycle(0, OP_SD, 0, 0);
    cycle(1, OP_SD, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, OP_SD, 0, 0);
    cycle(1, OP_SD, 0, 1);
    check("limit ready ir_write", 32'(ir_write), 1);
    cycle(1, OP_SD, 0, 0);
    check("limit decode state", 32'(state), 1);
    cycle(1, OP_SD, 0, 0);
    cycle(1, OP_SD, 0, 0);
    check("sd mem state", 32'(state), 3);
    check("sd mem strobes", 32'({mem_req, mem_we}), 3);
    #1 rst_n = 1'b0;
    #1;
    check("async mem_req/we", 32'({mem_req, mem_we}), 0);
    check("async state", 32'(state), 0);
    cycle(0, OP_SD, 0, 1);
    check("held strobes", 32'(strobes), 0);
    cycle(1, OP_SD, 0, 0);
    cycle(1, OP_SD, 0, 0);
    check("after abort state", 32'(state), 0);
    check("after abort mem_req", 32'(mem_req), 1);
    check("after abort retired", retired, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
